bfm_reservation_station: RTL and testbench

- Reservation station sitting directly upstream of the UBFM execute unit in the Tomasulo core.
- Buffers dispatched bitfield-move ops (source value or tag, imms, immr, destination tag) and snoops the common data bus (CDB) to wake waiting operands.
- Issues one ready op per cycle to the UBFM unit via a valid/ready handshake.

---
 rtl/bfm_reservation_station.sv | 149 ++++++++++++++
 tb/tb_bfm_reservation_station.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_reservation_station.sv
// bfm_reservation_station: buffers UBFM ops, snoops the CDB, issues one
// ready op per cycle. Optional age-ordered issue: BFM_RS_AGE_ORDER_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash all entries at the next edge
//   disp_*              dispatch request (valid/ready) and op fields
//   cdb_*               common data bus broadcast (tag, value)
//   iss_*               issue to UBFM unit (valid/ready) and op fields
//   occupancy           number of valid entries

module bfm_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic                     disp_src_rdy,
  input  logic [TAG_W-1:0]         disp_src_tag,
  input  logic [DATA_W-1:0]        disp_src_val,
  input  logic [5:0]               disp_imms,
  input  logic [5:0]               disp_immr,
  input  logic [TAG_W-1:0]         disp_dst_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_val,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [DATA_W-1:0]        iss_val_a,
  output logic [5:0]               iss_imms,
  output logic [5:0]               iss_immr,
  output logic [TAG_W-1:0]         iss_dst_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  src_rdy_q;
  logic [TAG_W-1:0]  src_tag_q [DEPTH];
  logic [DATA_W-1:0] src_val_q [DEPTH];
  logic [5:0]        imms_q    [DEPTH];
  logic [5:0]        immr_q    [DEPTH];
  logic [TAG_W-1:0]  dst_q     [DEPTH];
  logic [CW-1:0]     occ_q;

  logic [DEPTH-1:0]  rdy;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     free_idx;
  logic              disp_fire;
  logic              iss_fire;
  logic              disp_hit;

  assign rdy        = valid_q & src_rdy_q;
  assign occupancy  = occ_q;
  assign disp_ready = occ_q < CW'(DEPTH);
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_valid  = |rdy;
  assign iss_fire   = iss_valid && iss_ready;
  // operand produced on the CDB in the very cycle it is dispatched
  assign disp_hit   = cdb_valid && (cdb_tag == disp_src_tag);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

`ifdef BFM_RS_AGE_ORDER_EN
  // rank 0 is the oldest valid entry; ranks stay dense
  logic [IW-1:0] age_q [DEPTH];
  logic [IW-1:0] best;
  logic          found;

  always_comb begin
    sel   = '0;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && (!found || age_q[i] < best)) begin
        sel   = IW'(i);
        best  = age_q[i];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire && age_q[i] > age_q[sel]) begin
        age_q[i] <= age_q[i] - IW'(1);
      end
    end
    // newest op ranks behind every survivor
    if (disp_fire) begin
      age_q[free_idx] <= IW'(occ_q - CW'(iss_fire));
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) sel = IW'(i);
    end
  end
`endif

  assign iss_val_a   = src_val_q[sel];
  assign iss_imms    = imms_q[sel];
  assign iss_immr    = immr_q[sel];
  assign iss_dst_tag = dst_q[sel];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      occ_q <= occ_q + CW'(disp_fire) - CW'(iss_fire);
      if (iss_fire) valid_q[sel] <= 1'b0;
      if (disp_fire) valid_q[free_idx] <= 1'b1;
    end
  end

  // payload needs no reset; only valid entries are ever observed
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !src_rdy_q[i] && cdb_valid &&
          cdb_tag == src_tag_q[i]) begin
        src_rdy_q[i] <= 1'b1;
        src_val_q[i] <= cdb_val;
      end
    end
    if (disp_fire) begin
      src_rdy_q[free_idx] <= disp_src_rdy || disp_hit;
      src_val_q[free_idx] <= disp_src_rdy ? disp_src_val : cdb_val;
      src_tag_q[free_idx] <= disp_src_tag;
      imms_q[free_idx]    <= disp_imms;
      immr_q[free_idx]    <= disp_immr;
      dst_q[free_idx]     <= disp_dst_tag;
    end
  end

endmodule

// File: tb/tb_bfm_reservation_station.sv
// tb_bfm_reservation_station: directed + random bench for the UBFM
// reservation station against a slot/sequence-number reference model.

module tb_bfm_reservation_station;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic              disp_src_rdy;
  logic [TAG_W-1:0]  disp_src_tag;
  logic [DATA_W-1:0] disp_src_val;
  logic [5:0]        disp_imms;
  logic [5:0]        disp_immr;
  logic [TAG_W-1:0]  disp_dst_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_val;
  logic              iss_valid;
  logic              iss_ready;
  logic [DATA_W-1:0] iss_val_a;
  logic [5:0]        iss_imms;
  logic [5:0]        iss_immr;
  logic [TAG_W-1:0]  iss_dst_tag;
  logic [2:0]        occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bfm_reservation_station #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag),
    .disp_src_val(disp_src_val), .disp_imms(disp_imms),
    .disp_immr(disp_immr), .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_val_a(iss_val_a), .iss_imms(iss_imms),
    .iss_immr(iss_immr), .iss_dst_tag(iss_dst_tag),
    .occupancy(occupancy)
  );

  typedef struct {
    bit        v;
    bit        r;
    bit [4:0]  tag;
    bit [63:0] val;
    bit [5:0]  imms;
    bit [5:0]  immr;
    bit [4:0]  dst;
    int        seq;
  } ent_t;

  ent_t m [DEPTH];
  int   seqc = 0;

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].v) n++;
    return n;
  endfunction

  function automatic int msel();
    int s = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].r) begin
`ifdef BFM_RS_AGE_ORDER_EN
        if (s < 0 || m[i].seq < m[s].seq) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int s;
    int f;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      return;
    end
    s = msel();
    f = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) f = i;
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v && !m[i].r && m[i].tag == cdb_tag) begin
          m[i].r   = 1'b1;
          m[i].val = cdb_val;
        end
      end
    end
    if (s >= 0 && iss_ready) m[s].v = 1'b0;
    if (disp_valid && f >= 0) begin
      m[f].v    = 1'b1;
      m[f].tag  = disp_src_tag;
      m[f].imms = disp_imms;
      m[f].immr = disp_immr;
      m[f].dst  = disp_dst_tag;
      m[f].seq  = seqc;
      seqc++;
      if (disp_src_rdy) begin
        m[f].r   = 1'b1;
        m[f].val = disp_src_val;
      end else if (cdb_valid && cdb_tag == disp_src_tag) begin
        m[f].r   = 1'b1;
        m[f].val = cdb_val;
      end else begin
        m[f].r = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int s = msel();
    chk("occupancy", 64'(occupancy), 64'(mcount()));
    chk("disp_ready", 64'(disp_ready), 64'(mcount() < DEPTH));
    chk("iss_valid", 64'(iss_valid), 64'(s >= 0));
    if (s >= 0) begin
      chk("iss_val_a", iss_val_a, m[s].val);
      chk("iss_imms", 64'(iss_imms), 64'(m[s].imms));
      chk("iss_immr", 64'(iss_immr), 64'(m[s].immr));
      chk("iss_dst_tag", 64'(iss_dst_tag), 64'(m[s].dst));
    end
  endtask

  task automatic idle();
    rst          = 1'b0;
    flush        = 1'b0;
    disp_valid   = 1'b0;
    disp_src_rdy = 1'b0;
    disp_src_tag = '0;
    disp_src_val = '0;
    disp_imms    = '0;
    disp_immr    = '0;
    disp_dst_tag = '0;
    cdb_valid    = 1'b0;
    cdb_tag      = '0;
    cdb_val      = '0;
    iss_ready    = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic disp(input bit rdy, input logic [4:0] tag,
                      input logic [63:0] val, input logic [5:0] s,
                      input logic [5:0] r, input logic [4:0] dst);
    disp_valid   = 1'b1;
    disp_src_rdy = rdy;
    disp_src_tag = tag;
    disp_src_val = val;
    disp_imms    = s;
    disp_immr    = r;
    disp_dst_tag = dst;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [63:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_val   = val;
  endtask

  logic [4:0] exp_first;
  logic [4:0] exp_second;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_iss_valid", 64'(iss_valid), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);

    // ready-at-dispatch op issues next cycle
    disp(1'b1, 5'd0, 64'hFF, 6'd3, 6'd1, 5'd5);
    tick();
    chk("t1_iss_valid", 64'(iss_valid), 64'd1);
    chk("t1_val", iss_val_a, 64'hFF);
    chk("t1_imms", 64'(iss_imms), 64'd3);
    chk("t1_immr", 64'(iss_immr), 64'd1);
    chk("t1_dst", 64'(iss_dst_tag), 64'd5);
    chk("t1_occ", 64'(occupancy), 64'd1);
    iss_ready = 1'b1;
    tick();
    chk("t1_occ_after", 64'(occupancy), 64'd0);

    // waiting op woken by CDB
    disp(1'b0, 5'd7, 64'h0, 6'd0, 6'd0, 5'd2);
    tick();
    chk("t2_wait", 64'(iss_valid), 64'd0);
    tick();
    cdb(5'd7, 64'hF0);
    tick();
    chk("t2_wake", 64'(iss_valid), 64'd1);
    chk("t2_val", iss_val_a, 64'hF0);
    iss_ready = 1'b1;
    tick();

    // wakeup in the dispatch cycle
    disp(1'b0, 5'd9, 64'h0, 6'd4, 6'd2, 5'd8);
    cdb(5'd9, 64'h1234);
    tick();
    chk("t3_iss_valid", 64'(iss_valid), 64'd1);
    chk("t3_val", iss_val_a, 64'h1234);
    iss_ready = 1'b1;
    tick();

    // fill, overflow attempt, then one issue
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b1, 5'd0, 64'(i + 100), 6'(i), 6'(i), 5'(i + 10));
      tick();
    end
    chk("t4_full_occ", 64'(occupancy), 64'd4);
    chk("t4_full_rdy", 64'(disp_ready), 64'd0);
    disp(1'b1, 5'd0, 64'hDEAD, 6'd9, 6'd9, 5'd30);
    tick();
    chk("t4_ignored", 64'(occupancy), 64'd4);
    iss_ready = 1'b1;
    tick();
    chk("t4_one_free", 64'(disp_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      iss_ready = 1'b1;
      tick();
    end

    // flush with a same-cycle dispatch
    disp(1'b0, 5'd10, 64'h0, 6'd0, 6'd0, 5'd1);
    tick();
    disp(1'b0, 5'd11, 64'h0, 6'd0, 6'd0, 5'd2);
    tick();
    disp(1'b0, 5'd12, 64'h0, 6'd0, 6'd0, 5'd3);
    tick();
    flush = 1'b1;
    disp(1'b1, 5'd0, 64'h55, 6'd0, 6'd0, 5'd4);
    tick();
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_iss_valid", 64'(iss_valid), 64'd0);
    cdb(5'd10, 64'h77);
    tick();
    chk("t5_stale", 64'(iss_valid), 64'd0);

    // age order across slot reuse
    disp(1'b1, 5'd0, 64'h1, 6'd0, 6'd0, 5'd1);
    tick();
    disp(1'b0, 5'd3, 64'h0, 6'd1, 6'd1, 5'd20);
    tick();
    disp(1'b0, 5'd4, 64'h0, 6'd2, 6'd2, 5'd21);
    tick();
    iss_ready = 1'b1;
    tick();
    disp(1'b0, 5'd6, 64'h0, 6'd3, 6'd3, 5'd22);
    tick();
    cdb(5'd6, 64'h66);
    tick();
    cdb(5'd3, 64'h33);
    tick();
`ifdef BFM_RS_AGE_ORDER_EN
    exp_first  = 5'd20;
    exp_second = 5'd22;
`else
    exp_first  = 5'd22;
    exp_second = 5'd20;
`endif
    chk("t6_first", 64'(iss_dst_tag), 64'(exp_first));
    iss_ready = 1'b1;
    tick();
    chk("t6_second", 64'(iss_dst_tag), 64'(exp_second));
    iss_ready = 1'b1;
    cdb(5'd4, 64'h44);
    tick();
    for (int i = 0; i < 2; i++) begin
      iss_ready = 1'b1;
      tick();
    end
    chk("t6_empty", 64'(occupancy), 64'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        disp(1'($urandom), 5'($urandom_range(0, 7)),
             {$urandom, $urandom}, 6'($urandom), 6'($urandom),
             5'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        cdb(5'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      iss_ready = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
